// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: GPU fetch has absolute priority,
// CPU accesses go through a one-entry buffer and fill free cycles.
module vram_arbiter #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 32,
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               gpu_req,
   input  logic [ADDR_W-1:0]  gpu_addr,
   output logic [DATA_W-1:0]  gpu_q,
   output logic               gpu_valid,
   input  logic               cpu_start,
   input  logic               cpu_we,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic [DATA_W-1:0]  cpu_data,
   output logic [DATA_W-1:0]  cpu_q,
   output logic               cpu_busy,
   output logic               cpu_done,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [DATA_W-1:0]  ram_d,
   output logic               ram_we,
   input  logic [DATA_W-1:0]  ram_q,
   output logic [STALL_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      ISSUED,
      RDATA
   } state_t;

   localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
   localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

   state_t              state, state_n;
   logic                buf_we, buf_we_n;
   logic [ADDR_W-1:0]   buf_addr, buf_addr_n;
   logic [DATA_W-1:0]   buf_data, buf_data_n;
   logic [DATA_W-1:0]   cpu_q_n;
   logic                cpu_busy_n;
   logic                cpu_done_n;
   logic [ADDR_W-1:0]   ram_addr_n;
   logic [DATA_W-1:0]   ram_d_n;
   logic                ram_we_n;
   logic [STALL_W-1:0]  stall_n;
   logic [1:0]          gv_pipe;

   // GPU read data comes straight from the RAM; only the valid is tracked
   assign gpu_q     = ram_q;
   assign gpu_valid = gv_pipe[1];

   // Next-state and port-grant logic; GPU overrides the address last
   always_comb begin
      state_n    = state;
      buf_we_n   = buf_we;
      buf_addr_n = buf_addr;
      buf_data_n = buf_data;
      cpu_q_n    = cpu_q;
      cpu_busy_n = cpu_busy;
      cpu_done_n = 1'b0;
      ram_addr_n = ram_addr;
      ram_d_n    = ram_d;
      ram_we_n   = 1'b0;
      stall_n    = stall_cycles;
      unique case (state)
         IDLE: begin
            if (cpu_start) begin
               buf_we_n   = cpu_we;
               buf_addr_n = cpu_addr;
               buf_data_n = cpu_data;
               stall_n    = '0;
               cpu_busy_n = 1'b1;
               state_n    = PENDING;
            end
         end
         PENDING: begin
            if (gpu_req) begin
               if (stall_cycles != STALL_MAX)
                  stall_n = stall_cycles + STALL_ONE;
            end else begin
               ram_addr_n = buf_addr;
               ram_d_n    = buf_data;
               ram_we_n   = buf_we;
               state_n    = ISSUED;
            end
         end
         ISSUED: begin
            if (buf_we) begin
               cpu_done_n = 1'b1;
               cpu_busy_n = 1'b0;
               state_n    = IDLE;
            end else begin
               state_n = RDATA;
            end
         end
         RDATA: begin
            cpu_q_n    = ram_q;
            cpu_done_n = 1'b1;
            cpu_busy_n = 1'b0;
            state_n    = IDLE;
         end
      endcase
      if (gpu_req) begin
         ram_addr_n = gpu_addr;
         ram_we_n   = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_n;
   end

   // Request buffer, RAM port and CPU-side output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         buf_we       <= 1'b0;
         buf_addr     <= '0;
         buf_data     <= '0;
         cpu_q        <= '0;
         cpu_busy     <= 1'b0;
         cpu_done     <= 1'b0;
         ram_addr     <= '0;
         ram_d        <= '0;
         ram_we       <= 1'b0;
         stall_cycles <= '0;
      end else begin
         buf_we       <= buf_we_n;
         buf_addr     <= buf_addr_n;
         buf_data     <= buf_data_n;
         cpu_q        <= cpu_q_n;
         cpu_busy     <= cpu_busy_n;
         cpu_done     <= cpu_done_n;
         ram_addr     <= ram_addr_n;
         ram_d        <= ram_d_n;
         ram_we       <= ram_we_n;
         stall_cycles <= stall_n;
      end
   end

   // Two-stage GPU valid pipe matching address register plus RAM latency
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) gv_pipe <= 2'b00;
      else         gv_pipe <= {gv_pipe[0], gpu_req};
   end

endmodule
